// File: rtl/sample_framer.sv
// Turns each 16-bit averaged reading into a 5-byte frame (header, seq, msb, lsb, xor)
// and feeds it one byte at a time to a UART transmitter through a tx_start/tx_busy handshake.
module sample_framer #(
    parameter logic [7:0]  HEADER = 8'hA5,
    parameter int unsigned GAP    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [15:0] sample,
    input  logic        overrun_clr,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        frame_busy,
    output logic        overrun,
    output logic [7:0]  seq
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_HI,
        WAIT_LO,
        GAP_WAIT
    } state_t;

    localparam logic [7:0] GAP_LAST = (GAP == 0) ? 8'd0 : 8'(GAP - 1);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] sample_lat_q, sample_lat_d;
    logic [7:0]  seq_lat_q, seq_lat_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        frame_busy_q, frame_busy_d;
    logic        overrun_q, overrun_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  byte_sel;
    logic        byte_done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            gap_cnt_q    <= 8'd0;
            sample_lat_q <= 16'h0000;
            seq_lat_q    <= 8'h00;
            tx_data_q    <= 8'h00;
            frame_busy_q <= 1'b0;
            overrun_q    <= 1'b0;
            seq_q        <= 8'h00;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            gap_cnt_q    <= gap_cnt_d;
            sample_lat_q <= sample_lat_d;
            seq_lat_q    <= seq_lat_d;
            tx_data_q    <= tx_data_d;
            frame_busy_q <= frame_busy_d;
            overrun_q    <= overrun_d;
            seq_q        <= seq_d;
        end
    end

    // Frame bytes come from the latched copies so the source may move on after the strobe.
    always_comb begin
        case (idx_q)
            3'd0:    byte_sel = HEADER;
            3'd1:    byte_sel = seq_lat_q;
            3'd2:    byte_sel = sample_lat_q[15:8];
            3'd3:    byte_sel = sample_lat_q[7:0];
            default: byte_sel = seq_lat_q ^ sample_lat_q[15:8] ^ sample_lat_q[7:0];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        gap_cnt_d    = gap_cnt_q;
        sample_lat_d = sample_lat_q;
        seq_lat_d    = seq_lat_q;
        tx_data_d    = tx_data_q;
        frame_busy_d = frame_busy_q;
        seq_d        = seq_q;
        byte_done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    sample_lat_d = sample;
                    seq_lat_d    = seq_q;
                    idx_d        = 3'd0;
                    frame_busy_d = 1'b1;
                    state_d      = LOAD;
                end
            end
            LOAD: begin
                tx_data_d = byte_sel;
                state_d   = START;
            end
            START: begin
                if (!tx_busy) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    if (GAP > 0) begin
                        gap_cnt_d = 8'd0;
                        state_d   = GAP_WAIT;
                    end else begin
                        byte_done = 1'b1;
                    end
                end
            end
            GAP_WAIT: begin
                if (gap_cnt_q == GAP_LAST) byte_done = 1'b1;
                else gap_cnt_d = gap_cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        if (byte_done) begin
            if (idx_q < 3'd4) begin
                idx_d   = idx_q + 3'd1;
                state_d = LOAD;
            end else begin
                seq_d        = seq_q + 8'd1;
                frame_busy_d = 1'b0;
                state_d      = IDLE;
            end
        end

        // A strobe outside IDLE is dropped; a simultaneous clear loses to it.
        if (sample_valid && (state_q != IDLE)) overrun_d = 1'b1;
        else if (overrun_clr) overrun_d = 1'b0;
        else overrun_d = overrun_q;
    end

    always_comb begin
        tx_start   = (state_q == START) && !tx_busy;
        tx_data    = tx_data_q;
        frame_busy = frame_busy_q;
        overrun    = overrun_q;
        seq        = seq_q;
    end

endmodule

// File: tb/tb_sample_framer.sv
// Bench for sample_framer: two instances (GAP=0 and GAP=3), each with a UART busy model,
// checked every cycle against a frame/timing model plus literal frame and gap expectations.
module tb_sample_framer;

    localparam int GAP1 = 3;
    localparam int BIG  = 32'h7fff_ffff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        sample_valid;
    logic [15:0] sample;
    logic        overrun_clr;
    logic [1:0]  tx_busy = 2'b00;
    logic [1:0]  tx_start;
    logic [1:0][7:0] tx_data;
    logic [1:0]  frame_busy;
    logic [1:0]  overrun;
    logic [1:0][7:0] seq;

    sample_framer #(.HEADER(8'hA5), .GAP(0)) dut0 (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .overrun_clr(overrun_clr), .tx_busy(tx_busy[0]), .tx_start(tx_start[0]),
        .tx_data(tx_data[0]), .frame_busy(frame_busy[0]), .overrun(overrun[0]), .seq(seq[0])
    );

    sample_framer #(.HEADER(8'hA5), .GAP(GAP1)) dut1 (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .overrun_clr(overrun_clr), .tx_busy(tx_busy[1]), .tx_start(tx_start[1]),
        .tx_data(tx_data[1]), .frame_busy(frame_busy[1]), .overrun(overrun[1]), .seq(seq[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, expected %0h (t=%0t)", name, i, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] lit_frame(input int k);
        case (k)
            0:       return 40'hA5_00_12_34_26;
            1:       return 40'hA5_00_FF_FF_00;
            2:       return 40'hA5_01_00_00_01;
            3:       return 40'hA5_00_12_34_26;
            4:       return 40'hA5_00_00_C3_C3;
            5:       return 40'hA5_00_01_02_03;
            260:     return 40'hA5_FF_01_02_FC;
            262:     return 40'hA5_00_01_02_03;
            default: return 40'h0;
        endcase
    endfunction

    // UART model: busy rises right after an accepted tx_start and stays up busy_len cycles.
    int cyc = 0;
    int hold_until = 0;
    int busy_len = 20;
    int start_cnt [2] = '{0, 0};
    int seen_cnt [2] = '{0, 0};
    int bcnt [2] = '{0, 0};

    always @(posedge clk) begin
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (start_cnt[i] != seen_cnt[i]) begin
                seen_cnt[i] = start_cnt[i];
                bcnt[i] = busy_len;
            end else if (bcnt[i] > 0) begin
                bcnt[i]--;
            end
            tx_busy[i] = (bcnt[i] > 0) || (cyc < hold_until);
        end
    end

    // Behavioural model: per-instance frame bytes and the cycle each event must happen.
    int         ncyc = 0;
    bit         model_ok = 0;
    logic [7:0] m_bytes [2][5];
    int         m_ptr [2];
    bit         m_active [2], m_wfall [2], m_high [2], m_fb [2], m_ovr [2];
    logic [7:0] m_seq [2], m_txd [2];
    int         m_ready [2], m_done [2], last_fall [2];
    int         m_fidx = 0, f0cnt = 0;
    logic [39:0] cap0 = '0;

    always @(negedge clk) begin
        ncyc++;
        for (int i = 0; i < 2; i++) begin
            bit exp_start;
            bit fb_cur;
            int gap_i;
            gap_i = (i == 0) ? 0 : GAP1;
            exp_start = m_active[i] && (m_ptr[i] < 5) && !m_wfall[i] && (ncyc >= m_ready[i]) && !tx_busy[i];
            if (model_ok) begin
                chk("tx_start", i, 64'(tx_start[i]), 64'(exp_start));
                chk("tx_data", i, 64'(tx_data[i]), 64'(m_txd[i]));
                chk("frame_busy", i, 64'(frame_busy[i]), 64'(m_fb[i]));
                chk("overrun", i, 64'(overrun[i]), 64'(m_ovr[i]));
                chk("seq", i, 64'(seq[i]), 64'(m_seq[i]));
                if (tx_start[i] && m_active[i] && m_ptr[i] > 0)
                    chk("byte_gap", i, 64'(ncyc - last_fall[i]), (i == 0) ? 64'd2 : 64'd5);
            end
            if (tx_start[i]) begin
                start_cnt[i]++;
                if (i == 0) cap0 = {cap0[31:0], tx_data[0]};
            end
            fb_cur = m_fb[i];
            if (!reset) begin
                m_fb[i] = 0; m_ovr[i] = 0; m_seq[i] = 8'h00; m_txd[i] = 8'h00;
                m_active[i] = 0; m_wfall[i] = 0; m_high[i] = 0; m_ptr[i] = 0;
                m_ready[i] = BIG; m_done[i] = BIG;
            end else if (model_ok) begin
                if (m_wfall[i]) begin
                    if (tx_busy[i]) m_high[i] = 1;
                    else if (m_high[i]) begin
                        m_wfall[i] = 0;
                        last_fall[i] = ncyc;
                        if (m_ptr[i] < 5) m_ready[i] = ncyc + 2 + gap_i;
                        else m_done[i] = ncyc + 1 + gap_i;
                    end
                end
                if (exp_start) begin
                    m_ptr[i]++;
                    m_wfall[i] = 1;
                    m_high[i] = 0;
                    if (i == 0 && m_ptr[0] == 5 && lit_frame(m_fidx) != 40'h0)
                        chk("frame", 0, 64'(cap0), 64'(lit_frame(m_fidx)));
                end
                if (m_done[i] == ncyc + 1) begin
                    m_fb[i] = 0;
                    m_seq[i] = m_seq[i] + 8'd1;
                    m_active[i] = 0;
                    m_done[i] = BIG;
                end
                if (sample_valid && fb_cur) m_ovr[i] = 1;
                else if (overrun_clr) m_ovr[i] = 0;
                if (sample_valid && !fb_cur) begin
                    m_bytes[i][0] = 8'hA5;
                    m_bytes[i][1] = m_seq[i];
                    m_bytes[i][2] = sample[15:8];
                    m_bytes[i][3] = sample[7:0];
                    m_bytes[i][4] = m_seq[i] ^ sample[15:8] ^ sample[7:0];
                    m_ptr[i] = 0;
                    m_active[i] = 1;
                    m_fb[i] = 1;
                    m_ready[i] = ncyc + 2;
                    if (i == 0) begin
                        m_fidx = f0cnt;
                        f0cnt++;
                        cap0 = '0;
                    end
                end
                if (m_active[i] && m_ptr[i] < 5 && !m_wfall[i] && m_ready[i] == ncyc + 1)
                    m_txd[i] = m_bytes[i][m_ptr[i]];
            end
        end
        if (!reset) model_ok = 1;
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic strobe(input logic [15:0] val);
        sample = val;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        sample = ~val;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 4000 && (frame_busy != 2'b00 || tx_busy != 2'b00); k++) step();
        if (frame_busy != 2'b00 || tx_busy != 2'b00) chk("idle_timeout", 0, 64'(frame_busy), 64'd0);
    endtask

    task automatic wait_starts(input int target);
        int k;
        for (k = 0; k < 1000 && start_cnt[0] < target; k++) step();
        chk("start_wait", 0, 64'(start_cnt[0] >= target), 64'd1);
    endtask

    task automatic chk_reset_vals();
        for (int i = 0; i < 2; i++) begin
            chk("rst_tx_start", i, 64'(tx_start[i]), 64'd0);
            chk("rst_tx_data", i, 64'(tx_data[i]), 64'h00);
            chk("rst_frame_busy", i, 64'(frame_busy[i]), 64'd0);
            chk("rst_overrun", i, 64'(overrun[i]), 64'd0);
            chk("rst_seq", i, 64'(seq[i]), 64'h00);
        end
    endtask

    initial begin
        int base;
        reset = 1'b0;
        sample_valid = 1'b0;
        sample = 16'h0000;
        overrun_clr = 1'b0;
        step(3);
        reset = 1'b1;
        chk_reset_vals();
        $display("reset: outputs at reset values");

        strobe(16'h1234);
        chk("fb_after_strobe", 0, 64'(frame_busy[0]), 64'd1);
        wait_idle();
        chk("seq_after_single", 0, 64'(seq[0]), 64'h01);
        chk("fb_after_single", 0, 64'(frame_busy[0]), 64'd0);
        $display("single frame 1234: seq=%0h", seq[0]);

        do_reset();
        strobe(16'hFFFF);
        wait_idle();
        strobe(16'h0000);
        wait_idle();
        chk("seq_after_b2b", 0, 64'(seq[0]), 64'h02);
        chk("seq_after_b2b", 1, 64'(seq[1]), 64'h02);
        $display("back-to-back FFFF/0000: seq=%0h", seq[0]);

        do_reset();
        base = start_cnt[0];
        strobe(16'h1234);
        wait_starts(base + 2);
        strobe(16'hBEEF);
        chk("overrun_set", 0, 64'(overrun[0]), 64'd1);
        wait_idle();
        chk("overrun_held", 0, 64'(overrun[0]), 64'd1);
        chk("bytes_sent", 0, 64'(start_cnt[0] - base), 64'd5);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("overrun_cleared", 0, 64'(overrun[0]), 64'd0);
        $display("overrun with BEEF: overrun cleared to %0d", overrun[0]);

        do_reset();
        base = start_cnt[0];
        hold_until = cyc + 50;
        strobe(16'h00C3);
        step(44);
        chk("no_start_while_busy", 0, 64'(start_cnt[0] - base), 64'd0);
        wait_idle();
        $display("busy held 50 cycles: frame 00C3 sent");

        do_reset();
        busy_len = 4;
        for (int f = 0; f < 256; f++) begin
            strobe(16'h0102);
            wait_idle();
        end
        chk("seq_wrap", 0, 64'(seq[0]), 64'h00);
        chk("seq_wrap", 1, 64'(seq[1]), 64'h00);
        $display("256 frames of 0102: seq=%0h", seq[0]);

        busy_len = 20;
        base = start_cnt[0];
        strobe(16'h1234);
        wait_starts(base + 3);
        step(10);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_reset_vals();
        wait_idle();
        strobe(16'h0102);
        wait_idle();
        chk("seq_after_abort", 0, 64'(seq[0]), 64'h01);
        $display("reset mid-frame: restarted with seq 00");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_framer.md
# sample_framer

Packetizes each 16-bit averaged sensor reading into a fixed 5-byte frame and pushes it byte by byte into the UART transmitter. It sits directly downstream of the averaging stage, consuming its `promedio`/`sum_ready` result, and directly upstream of `uart_basic`, driving its `tx_start`/`tx_data` and watching its busy flag. A frame header, a sequence number and a checksum let the host resynchronize and detect dropped or corrupted readings.

## Interface
Parameters:
- `HEADER`, 8'hA5: first byte of every frame.
- `GAP`, 0: idle clock cycles inserted after each byte completes, before the next `tx_start`. Legal range is 0..255.

Ports:
- `clk` input 1: single system clock. All logic is on the rising edge.
- `reset` input 1: synchronous, active-low reset.
- `sample_valid` input 1: one-cycle strobe meaning `sample` holds a new average.
- `sample` input 16: averaged oscillator count.
- `overrun_clr` input 1: clears `overrun`.
- `tx_busy` input 1: UART transmitter busy flag.
- `tx_start` output 1: one-cycle request to the UART to send `tx_data`.
- `tx_data` output 8: byte to transmit.
- `frame_busy` output 1: high while a frame is in flight.
- `overrun` output 1: sticky flag, set when a sample was dropped.
- `seq` output 8: sequence number of the next frame to be sent.

## Operation
- Frame byte order: `HEADER`, `seq`, `sample[15:8]`, `sample[7:0]`, `chk`.
  - `chk` = `seq` ^ `sample[15:8]` ^ `sample[7:0]`.
- Capture:
  - `sample_valid` while IDLE latches `sample` and the current `seq` into internal registers and sets `frame_busy`.
  - The latched copies are used for the whole frame, so `sample` may change after the strobe.
- FSM states: IDLE, LOAD, START, WAIT_HI, WAIT_LO, GAP_WAIT.
  - **IDLE**: on `sample_valid`, capture, byte index := 0, go to LOAD.
  - **LOAD**: drive `tx_data` from byte index, go to START.
  - **START**: if `tx_busy`=0, assert `tx_start` for this cycle and go to WAIT_HI. Otherwise stay with `tx_start`=0.
  - **WAIT_HI**: wait for `tx_busy`=1, then go to WAIT_LO.
  - **WAIT_LO**: wait for `tx_busy`=0.
    - If GAP>0, go to GAP_WAIT.
    - Else, if index<4, index+1 and go to LOAD.
    - Else the frame is done: `seq` := `seq`+1 (mod 256, 255→0), `frame_busy` := 0, go to IDLE.
  - **GAP_WAIT**: count GAP cycles, then apply the same index/done decision as WAIT_LO.
- Overrun:
  - `sample_valid` in any state other than IDLE sets `overrun`. The sample is discarded and the frame in flight is unaffected.
  - `overrun_clr` clears `overrun`. If `overrun_clr` and an overrun event occur in the same cycle, set wins.
- `tx_data` is held stable from LOAD until leaving WAIT_LO. Between frames it keeps the last byte sent.

## Timing
- Reset values: `tx_start`=0, `tx_data`=8'h00, `frame_busy`=0, `overrun`=0, `seq`=8'h00, FSM=IDLE, byte index=0, gap counter=0.
- Reset asserted mid-frame aborts the frame immediately; all reset values apply on the next edge.
- `sample_valid` at edge t gives:
  - `frame_busy`=1 from t+1.
  - `tx_data`=`HEADER` from t+2.
  - `tx_start` pulse at t+2 at the earliest, when `tx_busy`=0.
- `tx_start` is exactly one cycle wide and is never asserted while `tx_busy`=1.
- Per-byte overhead on top of the UART byte time: 2 cycles (LOAD, START) plus GAP.
- `seq` increments on the same edge that `frame_busy` falls.
- `sample_valid` in the cycle `frame_busy` falls counts as an overrun, because the state is not yet IDLE. The first accepted strobe is one cycle later.

## Test plan
- **Single frame**: reset, then `sample`=16'h1234 with a `sample_valid` pulse, and a UART model that raises busy for 20 cycles. Required: bytes A5, 00, 12, 34, 26 in order; `seq`=01 after the frame; `frame_busy` low.
- **Back-to-back frames**: `sample`=16'hFFFF, then 16'h0000 after the first frame completes. Required: second frame is A5, 01, 00, 00, 01; then `seq`=02.
- **Overrun**: second `sample_valid` (16'hBEEF) during byte 2 of a frame. Required: current frame unchanged; `overrun`=1 and held; `overrun_clr` pulse → 0; BEEF never transmitted.
- **Busy held high**: `tx_busy` forced to 1 for 50 cycles when START is entered. Required: `tx_start` stays 0 until `tx_busy` falls, then a single pulse with `tx_data`=A5.
- **Sequence wrap**: 256 frames with `sample`=16'h0102. Required: frame 256 carries `seq` byte FF and checksum FC (FF^01^02); `seq` returns to 00.
- **Reset mid-frame**: `reset`=0 for 1 cycle during WAIT_LO of byte 3. Required: all outputs at reset values next cycle; next frame starts with `seq` byte 00; GAP=3 variant shows exactly 3 idle cycles between each `tx_busy` fall and the next `tx_start`.
